// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
//   - uart_state_e : FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - DBIT_DEF, SB_TICK_DEF, DVSR_DEF : default frame/baud constants
//   - max_int() : helper for deriving minimum counter widths
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 8 data bits, 1 stop bit, 100 MHz / (16 x 9600) oversampling divisor.
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int DVSR_DEF    = 651;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator shared by the UART transmitter
// and receiver.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   tick    : one-clk pulse every DVSR clk cycles (when the count is DVSR-1)
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DVSR = DVSR_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = max_int(1, $clog2(DVSR));
  localparam logic [CW-1:0] CNT_LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule : uart_baud_tick

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DBIT data bits LSB-first, 1 stop bit, no
// parity, sampled with a 16x oversampling tick.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   rx           : serial input, asynchronous to clk, idle high
//   rx_dout      : last received data word, held until the next frame ends
//   rx_done_tick : one-clk pulse when a frame completes
//   frame_err    : valid with rx_done_tick only; 1 = stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int DVSR    = DVSR_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int SW = max_int(4, $clog2(SB_TICK));
  localparam int NW = max_int(1, $clog2(DBIT));

  // Sample points in oversampling ticks: the start bit is checked half a
  // bit in, data bits a full bit later each, the stop bit after SB_TICK.
  localparam logic [SW-1:0] S_START_MID = SW'(7);
  localparam logic [SW-1:0] S_BIT_END   = SW'(15);
  localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic            s_tick;
  logic [1:0]      rx_sync_q;
  logic            rx_s;
  uart_state_e     state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;

  uart_baud_tick #(
    .DVSR (DVSR)
  ) u_baud_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (s_tick)
  );

  // NOTE: the synchronizer resets to 1 (idle line level) so releasing
  // reset never looks like a falling start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
    end
  end

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Leaves on the synchronized falling edge without waiting for a
          // tick; the free-running tick adds up to one tick of jitter.
          if (!rx_s) begin
            s_q     <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_START_MID) begin
              if (!rx_s) begin
                s_q     <= '0;
                n_q     <= '0;
                state_q <= DATA;
              end else begin
                // Line went back high before mid start bit: a glitch.
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_BIT_END) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_STOP_END) begin
              // Data is published even on a framing error; the host
              // decides what to do with it via frame_err.
              dout_q  <= b_q;
              done_q  <= 1'b1;
              ferr_q  <= ~rx_s;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side companion of the existing uart_tx, using the same frame format: 1 start bit, DBIT data bits LSB-first, 1 stop bit, no parity.
- Samples the serial line with a 16x oversampling tick from its own baud tick generator.
- Validates the start bit at mid-bit and samples each data and stop bit at mid-bit.
- Presents the assembled byte with a one-cycle done pulse and a framing-error flag to the host logic.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 651, clk cycles per oversampling tick (100 MHz / (16 x 9600)). The counter width is clog2(DVSR).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_dout  output  DBIT  last received data word; holds its value until the next frame completes.
- rx_done_tick  output  1  one-clk pulse when a frame has completed.
- frame_err  output  1  valid in the rx_done_tick cycle only; 1 = stop bit sampled low.

Behaviour:
- Reset (asynchronous assert, synchronous release on clk):
  - state=IDLE; tick counter, s_reg and n_reg = 0; b_reg = 0.
  - rx_dout = 0, rx_done_tick = 0, frame_err = 0.
  - Both synchronizer flops = 1.
- Input synchronizer: two-flop synchronizer on rx produces rx_s. The FSM only ever reads rx_s (2 clk of latency).
- Tick generator:
  - Free-running counter 0..DVSR-1; s_tick = 1 for one clk when the count is DVSR-1, then it wraps to 0.
  - Never reset by the FSM, so start-edge detection has up to 1 tick of jitter (allowed).
- Oversampling counter s_reg: width clog2(SB_TICK), at least 4 bits. It only advances on s_tick cycles.
- IDLE:
  - rx_s == 0 -> s_reg = 0, go to START.
  - Otherwise stay in IDLE. No tick is required to leave IDLE.
- START:
  - On s_tick with s_reg == 7 (mid start bit):
    - rx_s == 0 -> s_reg = 0, n_reg = 0, go to DATA.
    - rx_s == 1 -> glitch: return to IDLE with no output activity.
  - On any other s_tick -> s_reg + 1.
- DATA:
  - On s_tick with s_reg == 15 -> s_reg = 0; b_reg = {rx_s, b_reg[DBIT-1:1]}, i.e. LSB-first shift-in.
  - If n_reg == DBIT-1 go to STOP, else n_reg + 1.
  - On any other s_tick -> s_reg + 1.
- STOP:
  - On s_tick with s_reg == SB_TICK-1 (mid stop bit for SB_TICK=16):
    - rx_dout <= b_reg; rx_done_tick = 1 for that single clk; frame_err = ~rx_s.
    - Go to IDLE.
  - On any other s_tick -> s_reg + 1.
  - rx_dout is updated even when a framing error is flagged.
- Outside the done cycle, rx_done_tick = 0 and frame_err = 0. Both are registered outputs.
- Latency: rx_done_tick fires about 7 + 1 + 16*DBIT + SB_TICK ticks after the synchronized falling edge, i.e. about 9.5 bit times for 8N1.
- Back-to-back frames: the FSM is in IDLE from mid-stop onward, so a start bit immediately after the stop bit is caught. There is no dead time.
- Line held low (break): the frame completes with frame_err = 1. The FSM then re-enters START while the line stays low and produces further framing-error frames of all-zero data. This is accepted behaviour; no break detector.
- Reset mid-frame: the partial frame is discarded, no done pulse is produced, and reception resumes on the next falling edge after release.
- Illegal state encoding -> IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams IDLE=0, START=1, DATA=2, STOP=3 (also used by uart_tx);
  - default DBIT, SB_TICK and DVSR constants.
- One sub-module, uart_baud_tick:
  - parameter DVSR; ports clk, reset_n, tick.
  - uart_tx is to migrate to this same generator.
- The synchronizer is inline, as two flops.

Test Plan (DVSR=4, so 1 bit = 64 clk; DBIT=8; SB_TICK=16):
- Reset, then drive a clean 8N1 frame with data 0xA5 -> exactly one rx_done_tick, rx_dout=8'hA5, frame_err=0, about 608 clk after the falling edge.
- Low pulse of 3 ticks (12 clk) on idle line -> no rx_done_tick, FSM back in IDLE; a following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven 0 -> rx_done_tick=1 with frame_err=1, rx_dout=8'h81; the next good frame 0x7E gives frame_err=0.
- Back-to-back frames 0x00, 0xFF, 0x55 with zero idle gap -> three done pulses, values in order, no framing errors.
- Assert reset_n low during bit 4 of 0xC3, release, then send 0x5A -> no pulse for the aborted frame, rx_dout=8'h5A; all outputs at reset values while reset_n is low.
- Loopback uart_tx -> uart_rx with shared DVSR, sending 0x00..0xFF -> 256 done pulses, each rx_dout matching tx_din, frame_err never 1.
